// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter and receiver:
// FSM encoding, parity modes and data-length limits.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam logic [3:0] MIN_N_DATA = 4'd5;

  // Out-of-range lengths fall back to the widest supported frame.
  function automatic logic [3:0] clamp_n_data(input logic [3:0] n, input logic [3:0] n_max);
    logic [3:0] res;
    if ((n < MIN_N_DATA) || (n > n_max)) begin
      res = n_max;
    end else begin
      res = n;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Host/pad-side signal bundle of the configurable UART transmitter.
interface uart_tx_cfg_if #(
  parameter int NB_DATA = 8
);
  logic               i_tick;
  logic               i_tx_start;
  logic [NB_DATA-1:0] i_data;
  logic [3:0]         i_n_data;
  logic               i_parity_en;
  logic               i_parity_odd;
  logic               i_two_stop;
  logic               o_ready;
  logic               o_busy;
  logic               o_data;
  logic               o_tx_done;

  modport master (
    output i_tick, i_tx_start, i_data, i_n_data, i_parity_en, i_parity_odd, i_two_stop,
    input  o_ready, o_busy, o_data, o_tx_done
  );

  modport slave (
    input  i_tick, i_tx_start, i_data, i_n_data, i_parity_en, i_parity_odd, i_two_stop,
    output o_ready, o_busy, o_data, o_tx_done
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Oversampling tick counter: flags the tick that closes each bit period.
// Shared by the transmitter and the receiver.
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16,
  parameter int NB_OVS     = $clog2(OVERSAMPLE)
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_bit_end
);

  localparam logic [NB_OVS-1:0] LAST_CNT = NB_OVS'(OVERSAMPLE - 1);

  logic [NB_OVS-1:0] cnt_q;
  logic [NB_OVS-1:0] cnt_d;

  // Next count: held at zero while cleared, wraps on the last tick of a bit.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = {NB_OVS{1'b0}};
    end else if (i_tick) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d = {NB_OVS{1'b0}};
      end else begin
        cnt_d = cnt_q + NB_OVS'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Tick counter register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= {NB_OVS{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_bit_end = i_tick & ~i_clear & (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with a one-entry holding register
// so a queued frame follows the current one without idle time.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int NB_DATA    = 8,
  parameter int OVERSAMPLE = 16,
  parameter int NB_OVS     = $clog2(OVERSAMPLE)
) (
  input  logic         i_clock,
  input  logic         i_reset,
  uart_tx_cfg_if.slave bus
);

  localparam logic [3:0] MAX_N = 4'(NB_DATA);

  uart_state_e        state_q, state_d;
  logic               ready_q, ready_d;
  logic [NB_DATA-1:0] hold_data_q, hold_data_d;
  logic [3:0]         hold_n_q, hold_n_d;
  logic [1:0]         hold_mode_q, hold_mode_d;
  logic               hold_two_q, hold_two_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [3:0]         n_q, n_d;
  logic [1:0]         mode_q, mode_d;
  logic               two_q, two_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic               stop_cnt_q, stop_cnt_d;
  logic               par_q, par_d;
  logic               data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic accept_s;
  logic load_s;
  logic bit_end_s;
  logic timer_clear_s;

  assign accept_s      = bus.i_tx_start & ready_q;
  assign timer_clear_s = (state_q == ST_IDLE);

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE),
    .NB_OVS    (NB_OVS)
  ) u_bit_timer (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (timer_clear_s),
    .i_tick   (bus.i_tick),
    .o_bit_end(bit_end_s)
  );

  // Frame sequencing, holding-register handoff and next line level.
  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    hold_data_d = hold_data_q;
    hold_n_d    = hold_n_q;
    hold_mode_d = hold_mode_q;
    hold_two_d  = hold_two_q;
    shift_d     = shift_q;
    n_d         = n_q;
    mode_d      = mode_q;
    two_d       = two_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    par_d       = par_q;
    done_d      = 1'b0;
    load_s      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!ready_q) begin
          load_s  = 1'b1;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          par_d   = par_q ^ shift_q[0];
          shift_d = {1'b0, shift_q[NB_DATA-1:1]};
          if (bit_cnt_q == (n_q - 4'd1)) begin
            bit_cnt_d = 4'd0;
            state_d   = (mode_q != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          if (two_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            stop_cnt_d = 1'b0;
            done_d     = 1'b1;
            if (!ready_q) begin
              load_s  = 1'b1;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Parity accumulator starts at 1 for odd parity so the final XOR lands inverted.
    if (load_s) begin
      shift_d    = hold_data_q;
      n_d        = hold_n_q;
      mode_d     = hold_mode_q;
      two_d      = hold_two_q;
      bit_cnt_d  = 4'd0;
      stop_cnt_d = 1'b0;
      par_d      = (hold_mode_q == PAR_ODD);
      ready_d    = 1'b1;
    end else if (accept_s) begin
      hold_data_d = bus.i_data;
      hold_n_d    = clamp_n_data(bus.i_n_data, MAX_N);
      hold_mode_d = bus.i_parity_en ? (bus.i_parity_odd ? PAR_ODD : PAR_EVEN) : PAR_NONE;
      hold_two_d  = bus.i_two_stop;
      ready_d     = 1'b0;
    end else begin
      ready_d = ready_q;
    end

    case (state_d)
      ST_START:  data_d = 1'b0;
      ST_DATA:   data_d = shift_d[0];
      ST_PARITY: data_d = par_d;
      default:   data_d = 1'b1;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // All state and outputs are registered; reset returns the line to mark.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      hold_data_q <= {NB_DATA{1'b0}};
      hold_n_q    <= MAX_N;
      hold_mode_q <= PAR_NONE;
      hold_two_q  <= 1'b0;
      shift_q     <= {NB_DATA{1'b0}};
      n_q         <= MAX_N;
      mode_q      <= PAR_NONE;
      two_q       <= 1'b0;
      bit_cnt_q   <= 4'd0;
      stop_cnt_q  <= 1'b0;
      par_q       <= 1'b0;
      data_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      hold_data_q <= hold_data_d;
      hold_n_q    <= hold_n_d;
      hold_mode_q <= hold_mode_d;
      hold_two_q  <= hold_two_d;
      shift_q     <= shift_d;
      n_q         <= n_d;
      mode_q      <= mode_d;
      two_q       <= two_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      par_q       <= par_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.o_ready   = ready_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_data    = data_q;
  assign bus.o_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: directed frames, back-to-back, clamp,
// mid-frame reset and randomized frames against a tick-sampled line model.
module tb_uart_tx_cfg;
  localparam int NB_DATA = 8;
  localparam int OVS     = 16;
  localparam int LIMIT   = 5000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   tick_period = 1;
  int   tick_ph = 0;
  int   done_cnt = 0;
  logic cap[$];
  logic exp_bits[$];

  uart_tx_cfg_if #(.NB_DATA(NB_DATA)) bus ();

  uart_tx_cfg #(
    .NB_DATA   (NB_DATA),
    .OVERSAMPLE(OVS),
    .NB_OVS    (4)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Line monitor: one sample per tick while a frame is in progress.
  always @(negedge clk) begin
    if (bus.i_tick && bus.o_busy) cap.push_back(bus.o_data);
    if (bus.o_tx_done) done_cnt++;
  end

  initial begin
    bus.i_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_ph >= tick_period - 1) begin
        tick_ph = 0;
        bus.i_tick = 1'b1;
      end else begin
        tick_ph++;
        bus.i_tick = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: start, n data bits LSB first, optional parity, 1 or 2 stops.
  function automatic void push_frame(input logic [7:0] d, input logic [3:0] n_raw,
                                     input logic pe, input logic po, input logic ts);
    int   n;
    int   ones;
    logic [7:0] w;
    n = (n_raw < 4'd5 || n_raw > 4'd8) ? 8 : int'(n_raw);
    ones = 0;
    w = d;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_bits.push_back(w[i]);
      ones += int'(w[i]);
    end
    if (pe) exp_bits.push_back(po ? (ones % 2 == 0) : (ones % 2 == 1));
    exp_bits.push_back(1'b1);
    if (ts) exp_bits.push_back(1'b1);
  endfunction

  task automatic send(input logic [7:0] d, input logic [3:0] n, input logic pe,
                      input logic po, input logic ts);
    int guard;
    guard = 0;
    bus.i_data = d;
    bus.i_n_data = n;
    bus.i_parity_en = pe;
    bus.i_parity_odd = po;
    bus.i_two_stop = ts;
    bus.i_tx_start = 1'b1;
    while (!bus.o_ready && guard < LIMIT) begin
      step();
      guard++;
    end
    check("accept_timeout", 32'(guard >= LIMIT), 32'd0);
    step();
    bus.i_tx_start = 1'b0;
    bus.i_data = 8'($urandom);
    bus.i_n_data = 4'($urandom);
    bus.i_parity_en = 1'($urandom);
    bus.i_parity_odd = 1'($urandom);
    bus.i_two_stop = 1'($urandom);
    push_frame(d, n, pe, po, ts);
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!bus.o_tx_done && cycles < LIMIT) begin
      step();
      cycles++;
    end
    check("done_timeout", 32'(cycles >= LIMIT), 32'd0);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!(bus.o_ready && !bus.o_busy) && guard < 4 * LIMIT) begin
      step();
      guard++;
    end
    check("idle_timeout", 32'(guard >= 4 * LIMIT), 32'd0);
    repeat (2) step();
  endtask

  task automatic check_stream(input string tag);
    int nb;
    nb = exp_bits.size();
    check({tag, "_len"}, 32'(cap.size()), 32'(nb * OVS));
    for (int b = 0; b < nb; b++) begin
      logic [1:0] obs_v;
      if ((b + 1) * OVS <= cap.size()) begin
        obs_v = {1'b0, cap[b * OVS]};
        for (int s = 1; s < OVS; s++) begin
          if (cap[b * OVS + s] !== cap[b * OVS]) obs_v = 2'd2;
        end
      end else begin
        obs_v = 2'd3;
      end
      check($sformatf("%s_bit%0d", tag, b), 32'(obs_v), 32'(exp_bits[b]));
    end
    cap.delete();
    exp_bits.delete();
  endtask

  initial begin
    int k;
    int t;
    int d1;
    int d2;
    int gaps;
    int ready_back;
    int guard;
    int nf;

    bus.i_tx_start = 1'b0;
    bus.i_data = 8'h00;
    bus.i_n_data = 4'd8;
    bus.i_parity_en = 1'b0;
    bus.i_parity_odd = 1'b0;
    bus.i_two_stop = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    check("rst_ready", 32'(bus.o_ready), 32'd1);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_data", 32'(bus.o_data), 32'd1);
    check("rst_done", 32'(bus.o_tx_done), 32'd0);
    rst = 1'b0;
    step();

    // 8N1 0xA5, tick every cycle: latency and frame length.
    tick_period = 1;
    cap.delete();
    done_cnt = 0;
    send(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0);
    check("8n1_ready_drop", 32'(bus.o_ready), 32'd0);
    check("8n1_mark_before_start", 32'(bus.o_data), 32'd1);
    step();
    check("8n1_start_latency", 32'(bus.o_data), 32'd0);
    check("8n1_busy", 32'(bus.o_busy), 32'd1);
    wait_done(k);
    check("8n1_frame_cycles", 32'(k), 32'd160);
    step();
    check("8n1_busy_after_done", 32'(bus.o_busy), 32'd0);
    check("8n1_done_width", 32'(bus.o_tx_done), 32'd0);
    check_stream("8n1");
    check("8n1_done_cnt", 32'(done_cnt), 32'd1);

    // 7E2 0x03 and 5O1 0xFF.
    send(8'h03, 4'd7, 1'b1, 1'b0, 1'b1);
    wait_done(k);
    step();
    check("7e2_busy_after_done", 32'(bus.o_busy), 32'd0);
    check_stream("7e2");
    send(8'hFF, 4'd5, 1'b1, 1'b1, 1'b0);
    wait_done(k);
    step();
    check_stream("5o1");

    // Length above NB_DATA clamps to 8 data bits.
    send(8'h96, 4'd12, 1'b1, 1'b0, 1'b0);
    wait_done(k);
    step();
    check_stream("clamp");

    // Back-to-back frames.
    done_cnt = 0;
    send(8'h55, 4'd8, 1'b0, 1'b0, 1'b0);
    send(8'h0F, 4'd8, 1'b0, 1'b0, 1'b0);
    check("b2b_ready_held", 32'(bus.o_ready), 32'd0);
    t = 0;
    d1 = -1;
    d2 = -1;
    gaps = 0;
    ready_back = -1;
    while (t < LIMIT && d2 < 0) begin
      step();
      t++;
      if (bus.o_ready && ready_back < 0) ready_back = t;
      if (bus.o_tx_done) begin
        if (d1 < 0) d1 = t;
        else d2 = t;
      end else if (!bus.o_busy) begin
        gaps++;
      end
    end
    check("b2b_done_spacing", 32'(d2 - d1), 32'd160);
    check("b2b_ready_at_second_start", 32'(ready_back), 32'(d1));
    check("b2b_mark_gap", 32'(gaps), 32'd0);
    wait_idle();
    check_stream("b2b");
    check("b2b_done_cnt", 32'(done_cnt), 32'd2);

    // Randomized frames with random tick rates.
    for (int batch = 0; batch < 3; batch++) begin
      tick_period = $urandom_range(1, 3);
      done_cnt = 0;
      nf = $urandom_range(3, 5);
      for (int f = 0; f < nf; f++) begin
        send(8'($urandom), 4'($urandom_range(3, 13)), 1'($urandom), 1'($urandom), 1'($urandom));
      end
      wait_idle();
      check_stream($sformatf("rand%0d", batch));
      check($sformatf("rand%0d_done_cnt", batch), 32'(done_cnt), 32'(nf));
    end

    // Reset during the 3rd data bit, tick every 4th cycle, one word pending.
    tick_period = 4;
    done_cnt = 0;
    send(8'h3C, 4'd8, 1'b0, 1'b0, 1'b0);
    send(8'hC3, 4'd8, 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (cap.size() < 3 * OVS + 8 && guard < LIMIT) begin
      step();
      guard++;
    end
    check("rst_mid_reach", 32'(guard >= LIMIT), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_data", 32'(bus.o_data), 32'd1);
    check("rst_mid_ready", 32'(bus.o_ready), 32'd1);
    check("rst_mid_busy", 32'(bus.o_busy), 32'd0);
    check("rst_mid_done", 32'(bus.o_tx_done), 32'd0);
    repeat (2) step();
    rst = 1'b0;
    cap.delete();
    exp_bits.delete();
    done_cnt = 0;
    repeat (400) step();
    check("rst_mid_no_done", 32'(done_cnt), 32'd0);
    check("rst_mid_no_frame", 32'(cap.size()), 32'd0);
    check("rst_mid_line_mark", 32'(bus.o_data), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
